// File: rtl/data_mux_arbiter_if.sv
// data_mux_arbiter_if
//   Bundles the per-channel request side and the single output stage of
//   data_mux_arbiter.
//   Parameters : DATA_WIDTH (beat width), MSEL_WIDTH (select width),
//                NO_CHANNEL (requester count, 2..2**MSEL_WIDTH)
//   Signals    : in_valid/in_data/in_last/in_ready - per-channel beat handshake
//                out_valid/out_ready/out_data/out_sel/out_last - output stage
//   Modports   : slave  - the arbiter (consumes requests, drives output stage)
//                master - the environment (drives requests, accepts output)
interface data_mux_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned NO_CHANNEL = 2**MSEL_WIDTH
);
  logic [NO_CHANNEL-1:0] in_valid;
  logic [DATA_WIDTH-1:0] in_data [NO_CHANNEL];
  logic [NO_CHANNEL-1:0] in_last;
  logic [NO_CHANNEL-1:0] in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [MSEL_WIDTH-1:0] out_sel;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/data_mux_arbiter.sv
// data_mux_arbiter
//   Round-robin arbiter that shares one data path between NO_CHANNEL
//   valid/ready requesters and registers the winning beat into a single
//   output stage (1-cycle latency, 1 beat/cycle under continuous out_ready).
//   Ports:
//     clk   - clock, all logic on the rising edge
//     rst_n - synchronous active-low reset
//     bus   - data_mux_arbiter_if.slave: per-channel in_valid/in_data/in_last/
//             in_ready and output out_valid/out_ready/out_data/out_sel/out_last
//   Optional build macro ARB_PKT_LOCK_EN: when defined the grant stays on a
//   channel from its first beat until it transfers a beat with in_last=1, and
//   the pointer advances per packet. When undefined the pointer advances per
//   beat and in_last is only passed through to out_last.
module data_mux_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned NO_CHANNEL = 2**MSEL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mux_arbiter_if.slave bus
);

  logic [MSEL_WIDTH-1:0] ptr_q, ptr_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [MSEL_WIDTH-1:0] out_sel_q;
  logic                  out_last_q;

  logic                  load;
  logic                  rr_vld;
  logic [MSEL_WIDTH-1:0] rr_idx;
  logic                  grant_vld;
  logic [MSEL_WIDTH-1:0] grant_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [NO_CHANNEL-1:0] in_ready_w;
  logic                  xfer;
  logic                  unit_done;

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  lock_state_e           state_q, state_d;
  logic [MSEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
`endif

  assign load = !out_valid_q || bus.out_ready;

  // Two-pass search: first channels at or above the pointer, then wrap to
  // the lowest requester below it. Only indices < NO_CHANNEL are ever chosen.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int unsigned j = 0; j < NO_CHANNEL; j++) begin
      if (!rr_vld && bus.in_valid[j] && (MSEL_WIDTH'(j) >= ptr_q)) begin
        rr_vld = 1'b1;
        rr_idx = MSEL_WIDTH'(j);
      end
    end
    for (int unsigned j = 0; j < NO_CHANNEL; j++) begin
      if (!rr_vld && bus.in_valid[j]) begin
        rr_vld = 1'b1;
        rr_idx = MSEL_WIDTH'(j);
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  // While locked only the owning channel may be granted; if it drops
  // in_valid there is simply no grant and the lock is kept.
  always_comb begin
    grant_vld = rr_vld;
    grant_idx = rr_idx;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b0;
      grant_idx = lock_ch_q;
      for (int unsigned j = 0; j < NO_CHANNEL; j++) begin
        if ((MSEL_WIDTH'(j) == lock_ch_q) && bus.in_valid[j]) begin
          grant_vld = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    grant_vld = rr_vld;
    grant_idx = rr_idx;
  end
`endif

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned j = 0; j < NO_CHANNEL; j++) begin
      if (grant_idx == MSEL_WIDTH'(j)) begin
        sel_data = bus.in_data[j];
        sel_last = bus.in_last[j];
      end
    end
  end

  always_comb begin
    in_ready_w = '0;
    for (int unsigned j = 0; j < NO_CHANNEL; j++) begin
      in_ready_w[j] = rst_n && load && grant_vld && (grant_idx == MSEL_WIDTH'(j));
    end
  end

  assign xfer = |(in_ready_w & bus.in_valid);

`ifdef ARB_PKT_LOCK_EN
  assign unit_done = sel_last;
`else
  assign unit_done = 1'b1;
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && unit_done) begin
      if (grant_idx == MSEL_WIDTH'(NO_CHANNEL - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sel_q   <= grant_idx;
        out_last_q  <= sel_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (sel_last) begin
        state_d = ST_OPEN;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_data_mux_arbiter.sv
module tb_data_mux_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;
  localparam int unsigned NC = 4;

  logic clk;
  logic rst_n;

  data_mux_arbiter_if #(.DATA_WIDTH(DW), .MSEL_WIDTH(SW), .NO_CHANNEL(NC)) bus ();

  data_mux_arbiter #(.DATA_WIDTH(DW), .MSEL_WIDTH(SW), .NO_CHANNEL(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] vld;
    logic [NC-1:0] last;
    logic          ordy;
    logic [DW-1:0] base;
    logic [NC-1:0] exp_rdy;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [NC-1:0] vld, input logic [NC-1:0] last, input logic ordy,
                     input logic [DW-1:0] base, input logic [NC-1:0] exp_rdy);
    vec_t v;
    v.vld = vld; v.last = last; v.ordy = ordy; v.base = base; v.exp_rdy = exp_rdy;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [NC-1:0] vld, input logic [NC-1:0] last,
                       input logic ordy, input logic [DW-1:0] base);
    bus.in_valid  = vld;
    bus.in_last   = last;
    bus.out_ready = ordy;
    for (int i = 0; i < NC; i++) bus.in_data[i] = base + DW'(i);
  endtask

  // One cycle: drive after the edge, check output stage and in_ready at the
  // falling edge, then enqueue the beat the bench expects to be accepted.
  task automatic step(input logic [NC-1:0] vld, input logic [NC-1:0] last, input logic ordy,
                      input logic [DW-1:0] base, input logic [NC-1:0] exp_rdy, input string tag);
    beat_t b;
    drive(vld, last, ordy, base);
    @(negedge clk);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
    if (bus.out_valid && sb.size() != 0) begin
      b = sb[0];
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(b.d));
      chk({tag, " out_sel"},  32'(bus.out_sel),  32'(b.s));
      chk({tag, " out_last"}, 32'(bus.out_last), 32'(b.l));
      if (ordy) void'(sb.pop_front());
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    for (int g = 0; g < NC; g++) begin
      if (exp_rdy[g]) begin
        b.d = base + DW'(g);
        b.s = SW'(g);
        b.l = last[g];
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // round robin from pointer 0
    add(4'b1111, 4'b1111, 1'b1, 8'h10, 4'b0001);
    add(4'b1111, 4'b1111, 1'b1, 8'h10, 4'b0010);
    add(4'b1111, 4'b1111, 1'b1, 8'h10, 4'b0100);
    add(4'b1111, 4'b1111, 1'b1, 8'h10, 4'b1000);
    add(4'b1111, 4'b1111, 1'b1, 8'h10, 4'b0001);
    add(4'b0000, 4'b1111, 1'b1, 8'h10, 4'b0000);
    // backpressure: single ch2 beat A5 held for 3 stalled cycles
    add(4'b0100, 4'b0000, 1'b0, 8'hA3, 4'b0100);
    add(4'b1111, 4'b1111, 1'b0, 8'hA3, 4'b0000);
    add(4'b1111, 4'b1111, 1'b0, 8'hA3, 4'b0000);
    add(4'b1111, 4'b1111, 1'b0, 8'hA3, 4'b0000);
    add(4'b0000, 4'b1111, 1'b1, 8'hA3, 4'b0000);
    // sparse/wrap from pointer 3, then simultaneous in/out handshakes
    add(4'b0010, 4'b1111, 1'b1, 8'h20, 4'b0010);
    add(4'b1010, 4'b1111, 1'b1, 8'h20, 4'b1000);
    add(4'b0001, 4'b1111, 1'b1, 8'h30, 4'b0001);
    add(4'b0000, 4'b1111, 1'b1, 8'h30, 4'b0000);
    // ch1 three-beat packet (last on 3rd) against ch0/ch2 single beats
`ifdef ARB_PKT_LOCK_EN
    add(4'b0111, 4'b0101, 1'b1, 8'h50, 4'b0010);
    add(4'b0111, 4'b0101, 1'b1, 8'h58, 4'b0010);
    add(4'b0111, 4'b0111, 1'b1, 8'h60, 4'b0010);
    add(4'b0111, 4'b0101, 1'b1, 8'h68, 4'b0100);
`else
    add(4'b0111, 4'b0101, 1'b1, 8'h50, 4'b0010);
    add(4'b0111, 4'b0101, 1'b1, 8'h58, 4'b0100);
    add(4'b0111, 4'b0111, 1'b1, 8'h60, 4'b0001);
    add(4'b0111, 4'b0101, 1'b1, 8'h68, 4'b0010);
`endif
    add(4'b0000, 4'b1111, 1'b1, 8'h70, 4'b0000);
    // single requester, no bubbles
    add(4'b1000, 4'b1111, 1'b1, 8'h80, 4'b1000);
    add(4'b1000, 4'b1111, 1'b1, 8'h84, 4'b1000);
    add(4'b1000, 4'b1111, 1'b1, 8'h88, 4'b1000);
    add(4'b0000, 4'b1111, 1'b1, 8'h88, 4'b0000);

    // reset held 2 cycles with every channel requesting
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 8'h10);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d in_ready", c),  32'(bus.in_ready),  32'h0);
      chk($sformatf("rst%0d out_valid", c), 32'(bus.out_valid), 32'h0);
      chk($sformatf("rst%0d out_data", c),  32'(bus.out_data),  32'h0);
      chk($sformatf("rst%0d out_sel", c),   32'(bus.out_sel),   32'h0);
      chk($sformatf("rst%0d out_last", c),  32'(bus.out_last),  32'h0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].vld, tbl[k].last, tbl[k].ordy, tbl[k].base, tbl[k].exp_rdy,
           $sformatf("vec%0d", k));
    end

    // reset mid-transfer: held ch1 beat (not last) and pointer are discarded
    step(4'b0010, 4'b0000, 1'b0, 8'h30, 4'b0010, "pre-rst");
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b0, 8'h40);
    @(negedge clk);
    chk("midrst in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst out_valid", 32'(bus.out_valid), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 1'b1, 8'h40, 4'b0001, "post-rst");
    step(4'b0000, 4'b1111, 1'b1, 8'h40, 4'b0000, "post-drain");
    chk("scoreboard empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
